// File: rtl/cnn_rom_pkg.sv
// ---------------------------------------------------------------------------
// cnn_rom_pkg
//   Shared constants and types for the weight-ROM burst fetch logic.
//   ADDR_WIDTH : ROM address width (depth = 2**ADDR_WIDTH)
//   DATA_WIDTH : ROM word width
//   LEN_WIDTH  : burst length width, one wider than the address so that a
//                full-depth burst is encodable
//   fetch_state_t : sequencer states IDLE -> FETCH -> FLUSH -> IDLE
// ---------------------------------------------------------------------------
package cnn_rom_pkg;

    localparam int ADDR_WIDTH = 6;
    localparam int DATA_WIDTH = 32;
    localparam int LEN_WIDTH  = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/rom_fetch_out_reg.sv
// ---------------------------------------------------------------------------
// rom_fetch_out_reg
//   One-entry valid/ready output register carrying a data word plus a
//   last-beat flag. load captures a new word (and sets valid), clear drops
//   valid/last once the final word has been taken, otherwise everything holds.
// Ports
//   clk, rst  : clock, synchronous active-high reset
//   load      : capture din/last_in, assert valid
//   clear     : deassert valid and last (data left as is)
//   din       : word to capture
//   last_in   : last-beat flag to capture with din
//   dout      : registered word
//   valid     : dout holds an unconsumed word
//   last      : dout is the final beat of the burst
// ---------------------------------------------------------------------------
module rom_fetch_out_reg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  last_in,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid,
    output logic                  last
);

    always_ff @(posedge clk) begin
        if (rst) begin
            dout  <= '0;
            valid <= 1'b0;
            last  <= 1'b0;
        end else if (load) begin
            dout  <= din;
            valid <= 1'b1;
            last  <= last_in;
        end else if (clear) begin
            valid <= 1'b0;
            last  <= 1'b0;
        end
    end

endmodule

// File: rtl/rom_weight_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// rom_weight_fetch_ctrl
//   Burst read sequencer for the asynchronous-read weight ROM. On start it
//   walks the ROM address from base_addr for burst_len words (wrapping modulo
//   the ROM depth) and registers each word into a one-entry valid/ready stage
//   feeding the PE array. One word per cycle while the consumer is ready;
//   everything holds under backpressure.
//
// Optional feature (macro ROM_FETCH_LOOP_EN):
//   Adds input repeat_cnt[3:0]. The burst is replayed repeat_cnt+1 times
//   back-to-back; rom_addr reloads base_addr after each pass and out_last
//   marks only the final beat of the final pass. Without the macro the port
//   is absent and a single pass is fetched.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   start      : burst request, honoured only while idle
//   base_addr  : first ROM address of the burst
//   burst_len  : words in the burst, 0..2**ADDR_WIDTH
//   repeat_cnt : extra passes (only with ROM_FETCH_LOOP_EN)
//   busy       : burst in progress (cycle after accepted start until done)
//   done       : one-cycle completion pulse
//   rom_addr   : ROM address
//   rom_data   : ROM read data, combinational on rom_addr
//   out_data   : registered weight word
//   out_valid  : out_data valid
//   out_ready  : consumer accepts when out_valid & out_ready
//   out_last   : final beat of the burst
// ---------------------------------------------------------------------------
module rom_weight_fetch_ctrl #(
    parameter int ADDR_WIDTH = cnn_rom_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = cnn_rom_pkg::DATA_WIDTH,
    parameter int LEN_WIDTH  = cnn_rom_pkg::LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  burst_len,
`ifdef ROM_FETCH_LOOP_EN
    input  logic [3:0]            repeat_cnt,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    import cnn_rom_pkg::*;

    fetch_state_t          state, state_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic [LEN_WIDTH-1:0]  remaining, rem_n;
    logic                  busy_n, done_n;
    logic                  load, clear, last_in, final_pass, word_is_last;

`ifdef ROM_FETCH_LOOP_EN
    // Burst parameters kept for reloading at the start of each replay pass.
    logic [ADDR_WIDTH-1:0] base_q, base_n;
    logic [LEN_WIDTH-1:0]  len_q, len_n;
    logic [3:0]            pass_left, pass_n;

    assign final_pass = (pass_left == 4'd0);
`else
    assign final_pass = 1'b1;
`endif

    assign word_is_last = (remaining == LEN_WIDTH'(1));
    assign last_in      = word_is_last && final_pass;

    // State and control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rom_addr  <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef ROM_FETCH_LOOP_EN
            base_q    <= '0;
            len_q     <= '0;
            pass_left <= '0;
`endif
        end else begin
            state     <= state_n;
            rom_addr  <= addr_n;
            remaining <= rem_n;
            busy      <= busy_n;
            done      <= done_n;
`ifdef ROM_FETCH_LOOP_EN
            base_q    <= base_n;
            len_q     <= len_n;
            pass_left <= pass_n;
`endif
        end
    end

    // Next-state and register-enable logic
    always_comb begin
        state_n = state;
        addr_n  = rom_addr;
        rem_n   = remaining;
        busy_n  = busy;
        done_n  = 1'b0;
        load    = 1'b0;
        clear   = 1'b0;
`ifdef ROM_FETCH_LOOP_EN
        base_n  = base_q;
        len_n   = len_q;
        pass_n  = pass_left;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    if (burst_len == '0) begin
                        // Empty burst: report completion without ever going busy.
                        done_n = 1'b1;
                    end else begin
                        addr_n  = base_addr;
                        rem_n   = burst_len;
                        busy_n  = 1'b1;
                        state_n = FETCH;
`ifdef ROM_FETCH_LOOP_EN
                        base_n  = base_addr;
                        len_n   = burst_len;
                        pass_n  = repeat_cnt;
`endif
                    end
                end
            end
            FETCH: begin
                // The output slot is free if empty or being drained this cycle.
                if (!out_valid || out_ready) begin
                    load   = 1'b1;
                    addr_n = rom_addr + 1'b1;
                    rem_n  = remaining - 1'b1;
                    if (word_is_last) begin
                        if (final_pass) begin
                            state_n = FLUSH;
`ifdef ROM_FETCH_LOOP_EN
                        end else begin
                            addr_n = base_q;
                            rem_n  = len_q;
                            pass_n = pass_left - 1'b1;
`endif
                        end
                    end
                end
            end
            FLUSH: begin
                if (out_valid && out_ready) begin
                    clear   = 1'b1;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Output stage
    rom_fetch_out_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_reg (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .clear  (clear),
        .din    (rom_data),
        .last_in(last_in),
        .dout   (out_data),
        .valid  (out_valid),
        .last   (out_last)
    );

endmodule

// File: tb/tb_rom_weight_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rom_weight_fetch_ctrl
//   Scoreboard bench for rom_weight_fetch_ctrl. A behavioural ROM returns
//   32'hA000_0000 + address. Each accepted burst pushes its expected beats
//   (data, last) and one expected done pulse; a monitor pops and compares
//   every handshake, checks hold stability under backpressure and that done
//   arrives only after all beats. Define ROM_FETCH_LOOP_EN to also exercise
//   replay passes.
// ---------------------------------------------------------------------------
module tb_rom_weight_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  base_addr = '0;
    logic [6:0]  burst_len = '0;
`ifdef ROM_FETCH_LOOP_EN
    logic [3:0]  repeat_cnt = '0;
`endif
    logic        busy, done, out_valid, out_last;
    logic [5:0]  rom_addr;
    logic [31:0] rom_data, out_data;
    logic        out_ready = 1'b1;

    always #5 clk = ~clk;

    // Behavioural ROM: async read
    assign rom_data = 32'hA000_0000 + {26'd0, rom_addr};

    rom_weight_fetch_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .burst_len (burst_len),
`ifdef ROM_FETCH_LOOP_EN
        .repeat_cnt(repeat_cnt),
`endif
        .busy      (busy),
        .done      (done),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    int          tests = 0;
    int          fails = 0;
    logic [32:0] exp_q[$];
    int          exp_done = 0;
    bit          rand_ready = 1'b0;
    bit          force_ready = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: every pass reads base..base+len-1 modulo 64.
    task automatic push_burst(input int base, input int len, input int rep);
        for (int p = 0; p <= rep; p++) begin
            for (int i = 0; i < len; i++) begin
                exp_q.push_back({(p == rep) && (i == len - 1),
                                 32'hA000_0000 + 32'((base + i) % 64)});
            end
        end
        exp_done++;
    endtask

    // Called at posedge+1 of the start cycle; returns at posedge+1 of the next.
    task automatic start_burst(input int base, input int len, input int rep);
        base_addr = 6'(base);
        burst_len = 7'(len);
`ifdef ROM_FETCH_LOOP_EN
        repeat_cnt = 4'(rep);
`endif
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        push_burst(base, len, rep);
    endtask

    // Returns at posedge+1 of the cycle where done is high. Optionally fires
    // stray start requests while busy; those must be ignored.
    task automatic wait_done(input int maxc, input bit junk);
        for (int n = 0; n < maxc; n++) begin
            if (done) begin
                start = 1'b0;
                return;
            end
            if (junk && busy && $urandom_range(0, 7) == 0) begin
                start     = 1'b1;
                base_addr = 6'($urandom);
                burst_len = 7'($urandom_range(1, 64));
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        tests++;
        fails++;
        $display("FAIL wait_done: no done pulse within %0d cycles, required one", maxc);
    endtask

    // Consumer ready
    always begin
        @(posedge clk);
        #1;
        out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : force_ready;
    end

    // Monitor / scoreboard
    logic        hold_p = 1'b0;
    logic [31:0] hold_d;
    logic        hold_l;
    logic [32:0] mon_e;

    always @(negedge clk) begin
        if (hold_p) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", out_data, hold_d);
            chk("hold_last", 32'(out_last), 32'(hold_l));
        end
        hold_p = out_valid && !out_ready && !rst;
        hold_d = out_data;
        hold_l = out_last;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL beat_unexpected: got data %h, required no beat", out_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("beat_data", out_data, mon_e[31:0]);
                chk("beat_last", 32'(out_last), 32'(mon_e[32]));
            end
        end
        if (done) begin
            if (exp_done == 0) begin
                tests++;
                fails++;
                $display("FAIL done_unexpected: got done=1, required 0");
            end else begin
                chk("done_beats_left", 32'(exp_q.size()), 32'd0);
                exp_done--;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_addr", 32'(rom_addr), 32'd0);
        chk("rst_data", out_data, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: base 0, len 4, ready high: valid c2..c5, last c5, done c6
        start_burst(0, 4, 0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("t1_valid", 32'(out_valid), 32'((k >= 2) && (k <= 5)));
            chk("t1_last", 32'(out_last), 32'(k == 5));
            chk("t1_done", 32'(done), 32'(k == 6));
            chk("t1_busy", 32'(busy), 32'(k <= 5));
            if (k >= 2 && k <= 5) chk("t1_data", out_data, 32'hA000_0000 + 32'(k - 2));
        end

        // 2: address wrap 62,63,0,1
        @(posedge clk);
        #1;
        start_burst(62, 4, 0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("t2_addr", 32'(rom_addr), 32'((62 + k - 1) % 64));
        end
        wait_done(100, 1'b0);

        // 3: backpressure in c3..c4 holds the second word through c5
        @(posedge clk);
        #1;
        start_burst(0, 4, 0);
        @(negedge clk);
        @(negedge clk);
        chk("t3_data_c2", out_data, 32'hA000_0000);
        force_ready = 1'b0;
        @(negedge clk);
        chk("t3_data_c3", out_data, 32'hA000_0001);
        @(negedge clk);
        chk("t3_data_c4", out_data, 32'hA000_0001);
        force_ready = 1'b1;
        @(negedge clk);
        chk("t3_data_c5", out_data, 32'hA000_0001);
        chk("t3_valid_c5", 32'(out_valid), 32'd1);
        wait_done(100, 1'b0);

        // 4: zero-length burst
        @(posedge clk);
        #1;
        start_burst(7, 0, 0);
        @(negedge clk);
        chk("t4_done_c1", 32'(done), 32'd1);
        chk("t4_busy_c1", 32'(busy), 32'd0);
        chk("t4_valid_c1", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("t4_done_c2", 32'(done), 32'd0);
        chk("t4_busy_c2", 32'(busy), 32'd0);
        chk("t4_valid_c2", 32'(out_valid), 32'd0);

        // 5: start while busy is ignored; reset at c3 aborts the burst
        @(posedge clk);
        #1;
        start_burst(10, 8, 0);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = 6'd40;
        burst_len = 7'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        rst   = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_done = 0;
        @(negedge clk);
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_last", 32'(out_last), 32'd0);
        chk("t5_addr", 32'(rom_addr), 32'd0);
        @(posedge clk);
        #1;
        start_burst(5, 3, 0);
        wait_done(100, 1'b0);

`ifdef ROM_FETCH_LOOP_EN
        // 6: two passes of a two-word burst
        @(posedge clk);
        #1;
        start_burst(25, 2, 1);
        wait_done(100, 1'b0);
`endif

        // Randomized bursts with random backpressure and stray starts
        rand_ready = 1'b1;
        for (int b = 0; b < 30; b++) begin
            int len;
            int base;
            int rep;
            case (b)
                0:       len = 64;
                1:       len = 1;
                2:       len = 0;
                default: len = $urandom_range(0, 64);
            endcase
            base = $urandom_range(0, 63);
            rep  = 0;
`ifdef ROM_FETCH_LOOP_EN
            rep = $urandom_range(0, 3);
`endif
            if ($urandom_range(0, 1) == 0) begin
                @(posedge clk);
                #1;
            end
            start_burst(base, len, rep);
            wait_done(2000, 1'b1);
        end

        rand_ready = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("end_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("end_done_pending", 32'(exp_done), 32'd0);
        chk("end_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
